// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field layout, constants and running-max FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fp_pkg;

    localparam int FP_W     = 32;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_NEG_ZERO = 32'h8000_0000;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Exponent and mantissa together form the magnitude used for ordering.
    function automatic logic [EXP_MSB:0] fp_mag(input logic [FP_W-1:0] v);
        return v[EXP_MSB:0];
    endfunction

endpackage

// File: rtl/fp_gt.sv
// Strict sign-magnitude greater-than on raw single-precision bit patterns (gt = a > b).
// Latency: purely combinational.
// Backpressure: not applicable.
// Ports: a, b [31:0] operands; gt high when a orders strictly above b.
// NaN/Inf are not special-cased: they order by their bit patterns like any other value.
module fp_gt
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            gt
);

    logic             sign_a;
    logic             sign_b;
    logic [EXP_MSB:0] mag_a;
    logic [EXP_MSB:0] mag_b;

    assign sign_a = a[SIGN_BIT];
    assign sign_b = b[SIGN_BIT];
    assign mag_a  = fp_mag(a);
    assign mag_b  = fp_mag(b);

    always_comb begin
        gt = 1'b0;
        if (sign_a != sign_b) begin
            // Positive operand wins; this also places +0 above -0.
            gt = ~sign_a;
        end else if (!sign_a) begin
            gt = (mag_a > mag_b);
        end else begin
            // Both negative: smaller magnitude is the larger value.
            gt = (mag_a < mag_b);
        end
    end

endmodule

// File: rtl/fp_running_max.sv
// Per-frame maximum of a float stream plus index of its first occurrence.
// Latency: result valid the cycle after the in_last beat is accepted.
// Backpressure: in_ready low while a result is held; held result waits for out_ready.
// Ports: clk/rst_n; in_valid/in_ready/in_data/in_last sample stream;
//        out_valid/out_ready/out_max/out_idx/out_ovf result stream (all outputs registered).
module fp_running_max
    import fp_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_ovf
);

    state_t           state_q, state_d;
    logic             first_q, first_d;
    logic [IDX_W-1:0] cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;
    logic [FP_W-1:0]  max_q,   max_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             load_out;

    logic             out_valid_q;
    logic [FP_W-1:0]  out_max_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             out_ovf_q;

    logic             in_gt;

    fp_gt u_fp_gt (
        .a  (in_data),
        .b  (max_q),
        .gt (in_gt)
    );

    // Ready decodes only the state register, so the freshly freed slot after a
    // result transfer is not reusable until the following cycle.
    assign in_ready = (state_q == ACCUM);

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        max_d    = max_q;
        idx_d    = idx_q;
        load_out = 1'b0;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    first_d = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    // Counter wrapping means this frame now has more beats than
                    // the index can name; later indices are modulo.
                    if (&cnt_q) begin
                        ovf_d = 1'b1;
                    end
                    if (first_q) begin
                        max_d = in_data;
                        idx_d = '0;
                    end else if (in_gt) begin
                        max_d = in_data;
                        idx_d = cnt_q;
                    end
                    if (in_last) begin
                        load_out = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    first_d = 1'b1;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ACCUM;
                first_d = 1'b1;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            first_q <= 1'b1;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            max_q   <= FP_POS_ZERO;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
        end
    end

    // Overflow reported is the flag before the last beat: a wrap caused by the
    // last beat itself means exactly 2^IDX_W samples, which still fits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_max_q   <= FP_POS_ZERO;
            out_idx_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            out_max_q   <= max_d;
            out_idx_q   <= idx_d;
            out_ovf_q   <= ovf_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_idx   = out_idx_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fp_running_max.sv
// Bench for fp_running_max: directed frames plus randomized frames vs an ordering-key model.
// Latency: checks result one cycle after the last beat.
// Backpressure: random out_ready stalls with stability checks.
module tb_fp_running_max;

    localparam int IDX_W = 2;
    localparam int NIDX  = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_max;
    logic [IDX_W-1:0] out_idx;
    logic             out_ovf;

    int n_checks = 0;
    int n_errors = 0;

    fp_running_max #(.IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Map a float bit pattern onto an unsigned key whose natural order is the
    // value order: positives above all negatives, negatives reversed.
    function automatic logic [31:0] order_key(input logic [31:0] v);
        return v[31] ? {1'b0, ~v[30:0]} : {1'b1, v[30:0]};
    endfunction

    task automatic run_frame(input logic [31:0] s[$], input int hold, input bit gaps);
        logic [31:0] em;
        int          ei;
        logic        eo;
        em = s[0];
        ei = 0;
        for (int i = 1; i < s.size(); i++) begin
            if (order_key(s[i]) > order_key(em)) begin
                em = s[i];
                ei = i;
            end
        end
        eo = (s.size() > NIDX);

        for (int i = 0; i < s.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            check("in_ready_accum", {31'd0, in_ready}, 32'd1);
            check("out_valid_accum", {31'd0, out_valid}, 32'd0);
            in_valid = 1'b1;
            in_data  = s[i];
            in_last  = (i == s.size() - 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        check("out_valid_lat", {31'd0, out_valid}, 32'd1);
        check("in_ready_hold", {31'd0, in_ready}, 32'd0);
        check("out_max", out_max, em);
        check("out_idx", {30'd0, out_idx}, 32'(ei % NIDX));
        check("out_ovf", {31'd0, out_ovf}, {31'd0, eo});

        out_ready = 1'b0;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_max", out_max, em);
            check("stall_idx", {30'd0, out_idx}, 32'(ei % NIDX));
            check("stall_ovf", {31'd0, out_ovf}, {31'd0, eo});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_xfer_valid", {31'd0, out_valid}, 32'd0);
        check("post_xfer_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    function automatic logic [31:0] rand_sample();
        logic [31:0] pool [8];
        pool = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
                 32'h7F80_0000, 32'hFF80_0000, 32'h4000_0000, 32'hC000_0000};
        if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 7)];
        return $urandom;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];

        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_max", out_max, 32'd0);
        check("rst_out_idx", {30'd0, out_idx}, 32'd0);
        check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk); #1;

        q = {32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000};
        run_frame(q, 0, 1'b0);
        q = {32'hC000_0000, 32'hBF80_0000, 32'hBF80_0000};
        run_frame(q, 0, 1'b0);
        q = {32'h8000_0000, 32'h0000_0000};
        run_frame(q, 0, 1'b0);
        q = {32'h8000_0000};
        run_frame(q, 0, 1'b0);
        q = {32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000};
        run_frame(q, 5, 1'b0);
        q = {32'h4000_0000, 32'h3F80_0000};
        run_frame(q, 0, 1'b0);
        q = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h4120_0000};
        run_frame(q, 0, 1'b0);
        q = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4120_0000};
        run_frame(q, 0, 1'b0);

        // Partial frame killed by reset, then a fresh single-sample frame.
        in_valid = 1'b1; in_data = 32'h4040_0000; in_last = 1'b0;
        @(posedge clk); #1;
        in_data = 32'h4080_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_max", out_max, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_no_result", {31'd0, out_valid}, 32'd0);
        q = {32'h3F80_0000};
        run_frame(q, 0, 1'b0);

        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 7);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(rand_sample());
            run_frame(q, $urandom_range(0, 3), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
